disp_mux_sched: RTL and testbench

//  Time-multiplexing scheduler that shares one combinational hex-to-7-segment decoder between two digits.

---
 rtl/disp_mux_sched_if.sv | 20 ++
 rtl/disp_mux_sched.sv | 89 ++++++++
 tb/tb_disp_mux_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/disp_mux_sched_if.sv
// Digit-pair load bus and shared-decoder/anode drive for the two-digit display scheduler.
interface disp_mux_sched_if;
  logic [3:0] dig0_in;
  logic [3:0] dig1_in;
  logic       load;
  logic [3:0] hex_sel;
  logic [1:0] an_n;
  logic       pending;
  logic       frame_tick;

  modport master (
    output dig0_in, dig1_in, load,
    input  hex_sel, an_n, pending, frame_tick
  );

  modport slave (
    input  dig0_in, dig1_in, load,
    output hex_sel, an_n, pending, frame_tick
  );
endinterface

// File: rtl/disp_mux_sched.sv
// Two-digit time-multiplexing scheduler: SHOW0/BLK0/SHOW1/BLK1 with tear-free commit of
// staged digit pairs at the frame boundary (BLK1 -> SHOW0).
module disp_mux_sched #(
  parameter int unsigned DWELL = 24000,
  parameter int unsigned BLANK = 240
) (
  input  logic             clk,
  input  logic             reset,
  disp_mux_sched_if.slave  bus
);
  localparam int unsigned MAXN = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CW   = $clog2(MAXN + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

  typedef enum logic [1:0] {SHOW0, BLK0, SHOW1, BLK1} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [3:0]    stg0, stg1, act0, act1;
  logic          last_c;

  // Last cycle of the current phase; SHOW phases use DWELL, blanking phases BLANK.
  assign last_c = ((state == SHOW0) || (state == SHOW1)) ? (count == DWELL_LAST)
                                                         : (count == BLANK_LAST);

  // Outputs are updated on the same edge as the state so they always match it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= BLK1;
      count          <= '0;
      stg0           <= 4'h0;
      stg1           <= 4'h0;
      act0           <= 4'h0;
      act1           <= 4'h0;
      bus.an_n       <= 2'b11;
      bus.hex_sel    <= 4'h0;
      bus.pending    <= 1'b0;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.frame_tick <= 1'b0;

      if (bus.load) begin
        stg0 <= bus.dig0_in;
        stg1 <= bus.dig1_in;
      end

      if (bus.load) begin
        bus.pending <= 1'b1;
      end else if (last_c && (state == BLK1)) begin
        bus.pending <= 1'b0;
      end

      if (last_c) begin
        count <= '0;
        case (state)
          SHOW0: begin
            state    <= BLK0;
            bus.an_n <= 2'b11;
          end
          BLK0: begin
            state       <= SHOW1;
            bus.an_n    <= 2'b01;
            bus.hex_sel <= act1;
          end
          SHOW1: begin
            state    <= BLK1;
            bus.an_n <= 2'b11;
          end
          BLK1: begin
            // Commit edge: pre-load staging values become active.
            state          <= SHOW0;
            act0           <= stg0;
            act1           <= stg1;
            bus.an_n       <= 2'b10;
            bus.hex_sel    <= stg0;
            bus.frame_tick <= 1'b1;
          end
          default: begin
            state    <= BLK1;
            bus.an_n <= 2'b11;
          end
        endcase
      end else begin
        count <= count + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_disp_mux_sched.sv
// Directed bench for disp_mux_sched with DWELL=4, BLANK=2 (12-cycle frame).
module tb_disp_mux_sched;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   t = 0;
  logic [1:0] prev_an;
  int   run;

  always #5 clk = ~clk;

  disp_mux_sched_if bus ();

  disp_mux_sched #(.DWELL(4), .BLANK(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame position since reset release; -1 during the initial dark gap.
  function automatic int ph(input int tt);
    if (tt < 2) return -1;
    return (tt - 2) % 12;
  endfunction

  function automatic logic [1:0] exp_an(input int tt);
    int p;
    p = ph(tt);
    if (p < 0)  return 2'b11;
    if (p < 4)  return 2'b10;
    if (p < 6)  return 2'b11;
    if (p < 10) return 2'b01;
    return 2'b11;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    t++;
    chk("an_n", 8'(bus.an_n), 8'(exp_an(t)));
    chk("frame_tick", 8'(bus.frame_tick), 8'(ph(t) == 0));
  endtask

  task automatic step_to(input int p);
    for (int i = 0; i < 13 && ph(t) != p; i++) step();
  endtask

  task automatic do_load(input logic [3:0] d1, input logic [3:0] d0);
    bus.dig1_in = d1;
    bus.dig0_in = d0;
    bus.load    = 1'b1;
    step();
    bus.load    = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.load    = 1'b0;
    bus.dig0_in = 4'h0;
    bus.dig1_in = 4'h0;
    @(posedge clk);
    #1;
    chk("rst_an_n", 8'(bus.an_n), 8'h03);
    chk("rst_hex", 8'(bus.hex_sel), 8'h00);
    chk("rst_pending", 8'(bus.pending), 8'h00);
    chk("rst_tick", 8'(bus.frame_tick), 8'h00);
    reset = 1'b0;
    t = 0;

    // Steady frames: dark gap, then repeating SHOW0/BLK0/SHOW1/BLK1 pattern
    repeat (26) step();
    chk("steady_hex", 8'(bus.hex_sel), 8'h00);
    chk("steady_pending", 8'(bus.pending), 8'h00);

    // Mid-frame load during SHOW1
    step_to(6);
    chk("mid_hex_before", 8'(bus.hex_sel), 8'h00);
    do_load(4'hA, 4'h3);
    chk("mid_pending", 8'(bus.pending), 8'h01);
    chk("mid_hex_hold", 8'(bus.hex_sel), 8'h00);
    step_to(0);
    chk("mid_hex0", 8'(bus.hex_sel), 8'h03);
    chk("mid_pending_clr", 8'(bus.pending), 8'h00);
    step_to(6);
    chk("mid_hex1", 8'(bus.hex_sel), 8'h0A);

    // Load on the commit edge
    do_load(4'h6, 4'h4);
    step_to(11);
    do_load(4'h5, 4'h7);
    chk("coll_hex0", 8'(bus.hex_sel), 8'h04);
    chk("coll_pending", 8'(bus.pending), 8'h01);
    step_to(6);
    chk("coll_hex1", 8'(bus.hex_sel), 8'h06);
    step_to(0);
    chk("coll_next_hex0", 8'(bus.hex_sel), 8'h07);
    chk("coll_next_pending", 8'(bus.pending), 8'h00);
    step_to(6);
    chk("coll_next_hex1", 8'(bus.hex_sel), 8'h05);

    // Back-to-back loads in one frame: last wins
    step_to(1);
    do_load(4'h1, 4'h2);
    do_load(4'h8, 4'h9);
    chk("b2b_hex_hold", 8'(bus.hex_sel), 8'h07);
    step_to(6);
    chk("b2b_hex_hold1", 8'(bus.hex_sel), 8'h05);
    step_to(0);
    chk("b2b_hex0", 8'(bus.hex_sel), 8'h09);
    chk("b2b_pending", 8'(bus.pending), 8'h00);
    step_to(6);
    chk("b2b_hex1", 8'(bus.hex_sel), 8'h08);

    // Asynchronous reset at count 2 of SHOW1 with a load pending
    do_load(4'hC, 4'hD);
    chk("pre_rst_pending", 8'(bus.pending), 8'h01);
    step_to(8);
    #1;
    reset = 1'b1;
    #1;
    chk("async_an_n", 8'(bus.an_n), 8'h03);
    chk("async_hex", 8'(bus.hex_sel), 8'h00);
    chk("async_pending", 8'(bus.pending), 8'h00);
    chk("async_tick", 8'(bus.frame_tick), 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    t = 0;
    chk("post_rst_an_n", 8'(bus.an_n), 8'h03);
    step();
    step();
    chk("post_rst_hex", 8'(bus.hex_sel), 8'h00);
    chk("post_rst_pending", 8'(bus.pending), 8'h00);

    // Random loads: anodes never both on, phase lengths exact
    prev_an = bus.an_n;
    run = 1;
    for (int i = 0; i < 2000; i++) begin
      bus.load    = 1'($urandom_range(0, 1));
      bus.dig0_in = 4'($urandom_range(0, 15));
      bus.dig1_in = 4'($urandom_range(0, 15));
      step();
      chk("an_nonzero", 8'(bus.an_n == 2'b00), 8'h00);
      if (bus.an_n == prev_an) begin
        run++;
      end else begin
        chk("run_len", 8'(run), (prev_an == 2'b11) ? 8'd2 : 8'd4);
        prev_an = bus.an_n;
        run = 1;
      end
    end
    bus.load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
